// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode / control-word constants and the cs priority
//                decoder used by the ALU controller and datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Opcodes, sampled by the datapath on LOAD
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Bit positions inside the one-hot control word
  localparam int CS_IDLE    = 0;
  localparam int CS_LOAD    = 1;
  localparam int CS_ADD     = 2;
  localparam int CS_SUB     = 3;
  localparam int CS_SHIFT   = 4;
  localparam int CS_OUTPUT  = 5;
  localparam int CS_WAIT_LD = 6;
  localparam int CS_WAIT_OP = 7;

  // Single micro-operation selected from a (possibly multi-hot) control word
  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_LOAD   = 3'd1,
    ACT_OUTPUT = 3'd2,
    ACT_ADD    = 3'd3,
    ACT_SUB    = 3'd4,
    ACT_SHIFT  = 3'd5
  } act_e;

  // Priority LOAD > OUTPUT > ADD > SUBTRACT > SHIFT; wait/idle bits only hold
  function automatic act_e decode_cs(input logic [7:0] cs);
    if (cs[CS_LOAD])        return ACT_LOAD;
    else if (cs[CS_OUTPUT]) return ACT_OUTPUT;
    else if (cs[CS_ADD])    return ACT_ADD;
    else if (cs[CS_SUB])    return ACT_SUB;
    else if (cs[CS_SHIFT])  return ACT_SHIFT;
    else if (cs[CS_IDLE] | cs[CS_WAIT_LD] | cs[CS_WAIT_OP]) return ACT_HOLD;
    else                    return ACT_HOLD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : alu_addsub
//  Description : W-bit combinational adder/subtractor (y = a + b or a - b,
//                modular). Subtraction is a + ~b + 1.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : alu_datapath
//  Description : Operand/result datapath of the 8-bit ALU. Executes the
//                LOAD/ADD/SUBTRACT/SHIFT/OUTPUT micro-operations for add,
//                subtract, Booth multiply and non-restoring divide, and
//                exposes Q0/Q1/Asign/count7 for controller branching.
//  Options     : DIVZERO_DETECT_EN - adds div_err output and dividend shadow;
//                a divide by zero then yields res_lo=all-ones, res_hi=dividend.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cs,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             Q0,
  output logic             Q1,
  output logic             Asign,
  output logic             count7,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_valid
`ifdef DIVZERO_DETECT_EN
  ,
  output logic             div_err
`endif
);

  logic [WIDTH:0]   acc;     // A, one guard bit above the operand width
  logic [WIDTH-1:0] q_reg;   // Q
  logic [WIDTH-1:0] m_reg;   // M
  logic             q_m1;    // Booth extension bit Q_1
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;

  act_e             act;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic             at_end;

  assign act    = decode_cs(cs);
  assign at_end = (cnt == CNT_W'(WIDTH));

  // The divisor is unsigned; every other operation treats M as signed
  assign m_ext = (op_r == OP_DIV) ? {1'b0, m_reg} : {m_reg[WIDTH-1], m_reg};

  // One adder serves ADD, SUBTRACT and the remainder correction on OUTPUT
  alu_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a   (acc),
    .b   (m_ext),
    .sub (act == ACT_SUB),
    .y   (sum)
  );

  // Operand registers A, Q, M, Q_1, shift counter and latched opcode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      q_reg <= '0;
      m_reg <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      op_r  <= OP_ADD;
    end else begin
      case (act)
        ACT_LOAD: begin
          op_r  <= opcode;
          m_reg <= b_in;
          cnt   <= '0;
          q_m1  <= 1'b0;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            acc   <= {a_in[WIDTH-1], a_in};
            q_reg <= '0;
          end else begin
            acc   <= '0;
            q_reg <= a_in;
          end
        end
        ACT_ADD, ACT_SUB: begin
          acc <= sum;
          if (op_r == OP_DIV) q_reg[0] <= ~sum[WIDTH];
        end
        ACT_SHIFT: begin
          // Once WIDTH shifts are done the counter and operands freeze
          if (!at_end) begin
            cnt <= cnt + CNT_W'(1);
            case (op_r)
              OP_MUL:  {acc, q_reg, q_m1} <= {acc[WIDTH], acc, q_reg};
              OP_DIV:  {acc, q_reg}       <= {acc[WIDTH-1:0], q_reg, 1'b0};
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIVZERO_DETECT_EN
  logic [WIDTH-1:0] dvd_shadow;

  // Sticky divide-by-zero flag and dividend copy, both refreshed on LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_err    <= 1'b0;
      dvd_shadow <= '0;
    end else if (act == ACT_LOAD) begin
      div_err    <= (opcode == OP_DIV) && (b_in == '0);
      dvd_shadow <= a_in;
    end
  end
`endif

  // Result capture on OUTPUT; valid stays up until the next LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_hi    <= '0;
      res_lo    <= '0;
      res_valid <= 1'b0;
    end else if (act == ACT_LOAD) begin
      res_valid <= 1'b0;
    end else if (act == ACT_OUTPUT) begin
      res_valid <= 1'b1;
      case (op_r)
        OP_MUL: begin
          res_hi <= acc[WIDTH-1:0];
          res_lo <= q_reg;
        end
        OP_DIV: begin
`ifdef DIVZERO_DETECT_EN
          if (div_err) begin
            res_hi <= dvd_shadow;
            res_lo <= '1;
          end else begin
            res_hi <= acc[WIDTH] ? sum[WIDTH-1:0] : acc[WIDTH-1:0];
            res_lo <= q_reg;
          end
`else
          // A negative final remainder is corrected by adding M back
          res_hi <= acc[WIDTH] ? sum[WIDTH-1:0] : acc[WIDTH-1:0];
          res_lo <= q_reg;
`endif
        end
        default: begin
          res_hi <= {WIDTH{acc[WIDTH]}};
          res_lo <= acc[WIDTH-1:0];
        end
      endcase
    end
  end

  assign Q0     = q_reg[0];
  assign Q1     = q_m1;
  assign Asign  = acc[WIDTH];
  assign count7 = at_end;

endmodule
`default_nettype wire

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- Operand/result datapath for the 8-bit ALU. It responds to the one-hot control word driven by the ALU control unit.
- Executes LOAD / ADD / SUBTRACT / SHIFT / OUTPUT micro-operations for add, subtract, Booth multiply and non-restoring divide.
- Returns status bits Q0, Q1, Asign and count7 that the controller uses to branch.
- Holds the result registers read by the top level.

Parameters:
- WIDTH, 8, operand width; A is WIDTH+1 bits, Q and M are WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, width of the shift counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cs  in  8  one-hot control word: bit1 LOAD, bit2 ADD, bit3 SUBTRACT, bit4 SHIFT, bit5 OUTPUT; bits 0, 6, 7 mean hold.
- opcode  in  2  00 add, 01 sub, 10 mul, 11 div; sampled only on LOAD.
- a_in  in  WIDTH  operand X (addend, minuend, multiplier or dividend).
- b_in  in  WIDTH  operand Y (M: addend, subtrahend, multiplicand or divisor).
- Q0  out  1  Q[0].
- Q1  out  1  Booth extension bit Q_1.
- Asign  out  1  A[WIDTH], the sign of the accumulator.
- count7  out  1  high when cnt == WIDTH, i.e. WIDTH shifts completed.
- res_hi  out  WIDTH  result high half / remainder.
- res_lo  out  WIDTH  result low half / quotient.
- res_valid  out  1  result held valid.

Behaviour:
- Reset is one clock, clk; reset rst is asynchronous, active-low. While rst=0:
  - A, Q, M, Q_1, cnt and op_r are 0.
  - res_hi, res_lo and res_valid are 0.
  - Q0, Q1, Asign and count7 are therefore 0.
  - Takes effect immediately, including mid-operation. No partial result survives.
- Priority when cs is not one-hot: LOAD > OUTPUT > ADD > SUBTRACT > SHIFT. Only the highest-priority set bit acts. cs=0 or cs[0]/[6]/[7] alone means hold all state.
- All state updates on the clk edge after cs is presented, with 1-cycle latency. Status outputs are direct register taps, with no combinational path from cs.
- LOAD (all opcodes): op_r<=opcode; M<=b_in; cnt<=0; Q_1<=0; res_valid<=0. Per op_r:
  - 00/01: A<=sign-extended a_in; Q<=0.
  - 10: A<=0; Q<=a_in.
  - 11: A<=0; Q<=a_in (unsigned dividend; M treated unsigned).
- ADD: A<=A+sext(M), (WIDTH+1)-bit modular. If op_r=11, also Q[0]<=~A_new[WIDTH].
- SUBTRACT: A<=A-sext(M), modular. If op_r=11, also Q[0]<=~A_new[WIDTH].
- SHIFT: cnt<=cnt+1, saturating at WIDTH; A/Q/Q_1 hold when cnt==WIDTH. Per op_r:
  - 10: arithmetic right shift of {A,Q,Q_1}; A[WIDTH] is replicated.
  - 11: left shift of {A,Q}; Q[0]<=0.
  - 00/01: counter only.
- OUTPUT: res_valid<=1. Per op_r:
  - 00/01: res_lo<=A[WIDTH-1:0]; res_hi<={WIDTH{A[WIDTH]}}.
  - 10: {res_hi,res_lo}<={A[WIDTH-1:0],Q}, the signed product.
  - 11: res_lo<=Q. res_hi<=A[WIDTH-1:0], or (A+M)[WIDTH-1:0] when A[WIDTH]=1 (remainder correction in the capture cycle).
- res_valid stays high until the next LOAD or reset. Repeated OUTPUT recaptures the same values.
- Division contract: WIDTH × (SHIFT then ADD if Asign else SUBTRACT), then OUTPUT.
- Booth contract: WIDTH × (optional ADD/SUB per {Q0,Q1} = 01/10, then SHIFT), then OUTPUT.
- opcode changes after LOAD have no effect; op_r governs.

Optional Feature:
- DIVZERO_DETECT_EN defined:
  - LOAD with opcode=11 and b_in==0 sets sticky div_err (extra 1-bit output, reset 0, cleared on next LOAD).
  - OUTPUT then forces res_lo=all-ones and res_hi=Q-input dividend (held in a shadow register).
- Undefined: no div_err port or shadow register. Divide-by-zero produces the natural algorithm result.

Decomposition:
- Shared alu_pkg holds:
  - Opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - cs bit-index constants CS_LOAD=1, CS_ADD=2, CS_SUB=3, CS_SHIFT=4, CS_OUTPUT=5, CS_WAIT_LD=6, CS_WAIT_OP=7.
  - Controller and datapath both use the package.
- One natural sub-module: alu_addsub, a (WIDTH+1)-bit combinational adder/subtractor with a sub select. It is shared by ADD/SUBTRACT and the division remainder correction.
- Registers use the existing RegisterN/FF style with the active-low async reset.

Test Plan:
- Add: op=00, a=0x25, b=0x13; LOAD, ADD, OUTPUT -> res_lo=0x38, res_hi=0x00, res_valid=1 one cycle after OUTPUT.
- Sub: op=01, a=0x10, b=0x20; LOAD, SUB, OUTPUT -> Asign=1, res_lo=0xF0, res_hi=0xFF.
- Booth: op=10, a=0x05, b=0xFD (-3); after LOAD Q0=1, Q1=0; drive the Booth sequence -> count7=1 after 8th SHIFT, {res_hi,res_lo}=0xFFF1.
- Divide: op=11, a=100, b=7; 8×(SHIFT, ADD/SUB per Asign), OUTPUT -> res_lo=0x0E, res_hi=0x02. Also a=9, b=4 -> res_lo=2, res_hi=1, with the correction path exercised.
- Reset mid-op: rst=0 asserted asynchronously during a SHIFT cycle of a multiply -> all outputs 0 before the next edge. After release, hold until LOAD.
- Multi-hot/hold: cs=0x06 after a completed add -> only LOAD acts (res_valid drops, A reloads). cs=0x40 for 5 cycles -> no state change.
